// File: rtl/uc1611_rx.sv
// UC1611 parallel write-bus receiver: decodes the driver's command subset,
// tracks column/page addresses with auto-increment, and expands each 16-gray
// data byte into two framebuffer pixel writes via a 2-entry FIFO.
module uc1611_rx #(
  parameter int unsigned COLS  = 160,
  parameter int unsigned PAGES = 72
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lcd_data,
  input  logic       lcd_cd,
  input  logic       lcd_write,
  input  logic       lcd_cs,
  output logic       px_we,
  output logic [7:0] px_x,
  output logic [7:0] px_y,
  output logic [3:0] px_gray,
  output logic       disp_en,
  output logic [7:0] scroll,
  output logic [7:0] pot,
  output logic       overrun,
  output logic       cmd_err
);

  localparam logic [7:0] CaMax  = 8'(COLS - 1);
  localparam logic [6:0] PaMax  = 7'(PAGES - 1);
  localparam logic [7:0] RowMax = 8'(2 * PAGES - 1);

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] ca;
    logic [6:0] pa;
  } entry_t;

  // Control registers
  logic [7:0] ca_q, ca_d;
  logic [6:0] pa_q, pa_d;
  logic [7:0] sl_q, sl_d;
  logic [2:0] ac_q, ac_d;
  logic [2:0] dc_q, dc_d;
  logic       mx_q, mx_d;
  logic       my_q, my_d;
  logic [1:0] lc_q, lc_d;
  logic [7:0] pot_q, pot_d;
  logic       arg_q, arg_d;
  logic       cmd_err_q, cmd_err_d;
  logic       overrun_q, overrun_d;

  // FIFO and pixel output stage
  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       half_q, half_d;
  logic       px_we_q, px_we_d;
  logic [7:0] px_x_q, px_x_d;
  logic [7:0] px_y_q, px_y_d;
  logic [3:0] px_gray_q, px_gray_d;

  logic cmd_acc, dat_acc;
  assign cmd_acc = lcd_write & lcd_cs & ~lcd_cd;
  assign dat_acc = lcd_write & lcd_cs & lcd_cd;

  logic [7:0] inner, inner_max, outer, outer_max, inner_nx, outer_nx;

  // Command decode and address auto-increment
  always_comb begin
    ca_d      = ca_q;
    pa_d      = pa_q;
    sl_d      = sl_q;
    ac_d      = ac_q;
    dc_d      = dc_q;
    mx_d      = mx_q;
    my_d      = my_q;
    lc_d      = lc_q;
    pot_d     = pot_q;
    arg_d     = arg_q;
    cmd_err_d = 1'b0;

    // AC[1] selects which counter runs fastest
    if (ac_q[1]) begin
      inner     = {1'b0, pa_q};
      inner_max = {1'b0, PaMax};
      outer     = ca_q;
      outer_max = CaMax;
    end else begin
      inner     = ca_q;
      inner_max = CaMax;
      outer     = {1'b0, pa_q};
      outer_max = {1'b0, PaMax};
    end
    inner_nx = inner;
    outer_nx = outer;
    if (inner < inner_max) begin
      inner_nx = inner + 8'd1;
    end else if (ac_q[0]) begin
      inner_nx = '0;
      outer_nx = (outer >= outer_max) ? 8'd0 : outer + 8'd1;
    end

    if (cmd_acc) begin
      if (arg_q) begin
        // Argument byte of 0x81 is captured, never decoded
        pot_d = lcd_data;
        arg_d = 1'b0;
      end else begin
        unique casez (lcd_data)
          8'b0000_????: ca_d[3:0] = lcd_data[3:0];
          8'b0001_????: ca_d[7:4] = lcd_data[3:0];
          8'b0100_????: sl_d[3:0] = lcd_data[3:0];
          8'b0101_????: sl_d[7:4] = lcd_data[3:0];
          8'b0110_????: pa_d[3:0] = lcd_data[3:0];
          8'b0111_0???: pa_d[6:4] = lcd_data[2:0];
          8'h81:        arg_d = 1'b1;
          8'b1000_1???: ac_d = lcd_data[2:0];
          8'b1010_1???: dc_d = lcd_data[2:0];
          8'b1100_0???: begin
            mx_d = lcd_data[1];
            my_d = lcd_data[2];
          end
          8'b1101_00??: lc_d = lcd_data[1:0];
          8'hE2: begin
            ca_d  = '0;
            pa_d  = '0;
            sl_d  = '0;
            ac_d  = 3'b001;
            dc_d  = '0;
            mx_d  = 1'b0;
            my_d  = 1'b0;
            lc_d  = '0;
            pot_d = '0;
            arg_d = 1'b0;
          end
          8'b0010_????, 8'b1000_01??, 8'b1010_00??, 8'b1110_10??: begin
          end
          default: cmd_err_d = 1'b1;
        endcase
      end
    end else if (dat_acc) begin
      if (ac_q[1]) begin
        pa_d = inner_nx[6:0];
        ca_d = outer_nx;
      end else begin
        ca_d = inner_nx;
        pa_d = outer_nx[6:0];
      end
    end
  end

  entry_t     head;
  logic       nonempty, full, pop, push_req, push, drop;
  logic [7:0] row;

  // FIFO bookkeeping and two-pixel expansion of the head entry
  always_comb begin
    head     = mem_q[rd_ptr_q];
    nonempty = (cnt_q != 2'd0);
    full     = (cnt_q == 2'd2);
    // Head retires on its second pixel; that slot is reusable the same cycle
    pop      = nonempty & half_q;
    push_req = dat_acc & (lc_q == 2'b10);
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{data: lcd_data, ca: ca_q, pa: pa_q};
    end
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    half_d    = nonempty ? ~half_q : half_q;
    overrun_d = overrun_q | drop;

    row       = {head.pa, half_q};
    px_we_d   = nonempty & (head.ca <= CaMax) & (head.pa <= PaMax);
    px_x_d    = mx_q ? CaMax - head.ca : head.ca;
    px_y_d    = my_q ? RowMax - row : row;
    px_gray_d = half_q ? head.data[7:4] : head.data[3:0];
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ca_q      <= '0;
      pa_q      <= '0;
      sl_q      <= '0;
      ac_q      <= 3'b001;
      dc_q      <= '0;
      mx_q      <= 1'b0;
      my_q      <= 1'b0;
      lc_q      <= '0;
      pot_q     <= '0;
      arg_q     <= 1'b0;
      cmd_err_q <= 1'b0;
      overrun_q <= 1'b0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= '0;
      half_q    <= 1'b0;
      px_we_q   <= 1'b0;
      px_x_q    <= '0;
      px_y_q    <= '0;
      px_gray_q <= '0;
    end else begin
      ca_q      <= ca_d;
      pa_q      <= pa_d;
      sl_q      <= sl_d;
      ac_q      <= ac_d;
      dc_q      <= dc_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      lc_q      <= lc_d;
      pot_q     <= pot_d;
      arg_q     <= arg_d;
      cmd_err_q <= cmd_err_d;
      overrun_q <= overrun_d;
      mem_q[0]  <= mem_d[0];
      mem_q[1]  <= mem_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      px_we_q   <= px_we_d;
      px_x_q    <= px_x_d;
      px_y_q    <= px_y_d;
      px_gray_q <= px_gray_d;
    end
  end

  assign px_we   = px_we_q;
  assign px_x    = px_x_q;
  assign px_y    = px_y_q;
  assign px_gray = px_gray_q;
  assign disp_en = |dc_q;
  assign scroll  = sl_q;
  assign pot     = pot_q;
  assign overrun = overrun_q;
  assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_uc1611_rx.sv
// Directed and randomized bench for uc1611_rx with a transaction-level model.
module tb_uc1611_rx;
  localparam int COLS  = 160;
  localparam int PAGES = 72;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] lcd_data = '0;
  logic       lcd_cd = 1'b0;
  logic       lcd_write = 1'b0;
  logic       lcd_cs = 1'b0;
  logic       px_we;
  logic [7:0] px_x, px_y, scroll, pot;
  logic [3:0] px_gray;
  logic       disp_en, overrun, cmd_err;

  uc1611_rx #(.COLS(COLS), .PAGES(PAGES)) dut (
    .clk(clk), .reset(reset), .lcd_data(lcd_data), .lcd_cd(lcd_cd),
    .lcd_write(lcd_write), .lcd_cs(lcd_cs), .px_we(px_we), .px_x(px_x),
    .px_y(px_y), .px_gray(px_gray), .disp_en(disp_en), .scroll(scroll),
    .pot(pot), .overrun(overrun), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int g;} pix_t;
  pix_t expq[$];
  int n_pass = 0;
  int n_total = 0;
  int px_count = 0;

  // Reference model state
  int m_ca, m_pa, m_sl, m_ac, m_dc, m_mx, m_my, m_lc, m_pot, m_arg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    m_ca = 0; m_pa = 0; m_sl = 0; m_ac = 1; m_dc = 0;
    m_mx = 0; m_my = 0; m_lc = 0; m_pot = 0; m_arg = 0;
  endfunction

  // Returns 1 when the command is unrecognised
  function automatic bit model_cmd(input int d);
    if (m_arg != 0) begin
      m_pot = d; m_arg = 0; return 1'b0;
    end
    if (d <= 'h0F) m_ca = (m_ca / 16) * 16 + d % 16;
    else if (d <= 'h1F) m_ca = (d % 16) * 16 + m_ca % 16;
    else if (d <= 'h2F) ;
    else if (d >= 'h40 && d <= 'h4F) m_sl = (m_sl / 16) * 16 + d % 16;
    else if (d >= 'h50 && d <= 'h5F) m_sl = (d % 16) * 16 + m_sl % 16;
    else if (d >= 'h60 && d <= 'h6F) m_pa = (m_pa / 16) * 16 + d % 16;
    else if (d >= 'h70 && d <= 'h77) m_pa = (d % 8) * 16 + m_pa % 16;
    else if (d == 'h81) m_arg = 1;
    else if (d >= 'h84 && d <= 'h87) ;
    else if (d >= 'h88 && d <= 'h8F) m_ac = d % 8;
    else if (d >= 'hA0 && d <= 'hA3) ;
    else if (d >= 'hA8 && d <= 'hAF) m_dc = d % 8;
    else if (d >= 'hC0 && d <= 'hC7) begin m_mx = (d / 2) % 2; m_my = (d / 4) % 2; end
    else if (d >= 'hD0 && d <= 'hD3) m_lc = d % 4;
    else if (d == 'hE2) model_reset();
    else if (d >= 'hE8 && d <= 'hEB) ;
    else return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_data(input int d, input bit dropped);
    pix_t p;
    int row;
    if (m_lc == 2 && !dropped && m_ca < COLS && m_pa < PAGES) begin
      for (int h = 0; h < 2; h++) begin
        row = 2 * m_pa + h;
        p.x = (m_mx != 0) ? COLS - 1 - m_ca : m_ca;
        p.y = (m_my != 0) ? 2 * PAGES - 1 - row : row;
        p.g = (h == 0) ? d % 16 : d / 16;
        expq.push_back(p);
      end
    end
    if ((m_ac / 2) % 2 == 1) begin
      if (m_pa < PAGES - 1) m_pa++;
      else if (m_ac % 2 == 1) begin
        m_pa = 0; m_ca = (m_ca >= COLS - 1) ? 0 : m_ca + 1;
      end
    end else begin
      if (m_ca < COLS - 1) m_ca++;
      else if (m_ac % 2 == 1) begin
        m_ca = 0; m_pa = (m_pa >= PAGES - 1) ? 0 : m_pa + 1;
      end
    end
  endfunction

  // One clock; pixels are scored against the model queue
  task automatic tick();
    pix_t e;
    @(posedge clk);
    #1;
    if (px_we === 1'b1) begin
      px_count++;
      if (expq.size() == 0) begin
        check("px_spurious", px_we, 0);
      end else begin
        e = expq.pop_front();
        check("px_x", px_x, e.x);
        check("px_y", px_y, e.y);
        check("px_gray", px_gray, e.g);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input bit cd, input int d, input bit dropped = 1'b0);
    bit err;
    lcd_cd = cd; lcd_data = 8'(d); lcd_write = 1'b1; lcd_cs = 1'b1;
    tick();
    lcd_write = 1'b0;
    if (!cd) begin
      err = model_cmd(d);
      check("cmd_err", cmd_err, err);
    end else begin
      model_data(d, dropped);
    end
    check("disp_en", disp_en, (m_dc != 0));
    check("scroll", scroll, m_sl);
    check("pot", pot, m_pot);
  endtask

  int init_seq[16] = '{'hC6, 'hA1, 'h2A, 'hD2, 'hEA, 'h81, 'h00, 'h84,
                       'h8B, 'hAF, 'h40, 'h50, 'h60, 'h70, 'h00, 'h10};
  int c0;
  int k;

  initial begin
    model_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_px_we", px_we, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_disp_en", disp_en, 0);
    check("rst_scroll", scroll, 0);
    check("rst_pot", pot, 0);
    @(negedge clk) reset = 1'b1;

    // LC=0: data discarded, no overrun
    c0 = px_count;
    wr(1, 'h33);
    idle(3);
    check("lc0_no_px", px_count - c0, 0);
    check("lc0_overrun", overrun, 0);

    // Init sequence
    foreach (init_seq[i]) wr(0, init_seq[i]);
    check("init_disp_en", disp_en, 1);
    check("init_pot", pot, 0);
    check("init_scroll", scroll, 0);

    // Unmapped single byte with exact latency
    wr(0, 'hC0); wr(0, 'h89); wr(0, 'h00); wr(0, 'h10); wr(0, 'h60); wr(0, 'h70);
    wr(1, 'hA5);
    check("lat_edge0_we", px_we, 0);
    tick();
    check("lat_p1_we", px_we, 1);
    check("lat_p1_gray", px_gray, 5);
    tick();
    check("lat_p2_we", px_we, 1);
    check("lat_p2_y", px_y, 1);
    check("lat_p2_gray", px_gray, 10);
    tick();
    check("lat_done_we", px_we, 0);

    // Page-first with page wrap into next column
    c0 = px_count;
    wr(0, 'h8B); wr(0, 'h03); wr(0, 'h10); wr(0, 'h67); wr(0, 'h74);
    wr(1, 'h11); idle(2);
    wr(1, 'h22); idle(3);
    check("pf_px_cnt", px_count - c0, 4);

    // Mirrored mapping
    wr(0, 'hC6); wr(0, 'h00); wr(0, 'h10); wr(0, 'h60); wr(0, 'h70);
    wr(1, 'h0F); idle(3);

    // Unknown command, and a strobe without chip select
    wr(0, 'hF0);
    tick();
    check("cmd_err_once", cmd_err, 0);
    lcd_cd = 1'b0; lcd_data = 8'hF0; lcd_write = 1'b1; lcd_cs = 1'b0;
    tick();
    lcd_write = 1'b0;
    check("cs_low_ignored", cmd_err, 0);

    // Four back-to-back bytes: the fourth overruns
    wr(0, 'hC0); wr(0, 'h89); wr(0, 'h00); wr(0, 'h10); wr(0, 'h60); wr(0, 'h70);
    c0 = px_count;
    wr(1, 'h21); wr(1, 'h43); wr(1, 'h65);
    wr(1, 'h87, 1'b1);
    idle(6);
    check("burst_px_cnt", px_count - c0, 6);
    check("burst_overrun", overrun, 1);
    wr(1, 'h99); idle(3);
    check("after_burst_q", expq.size(), 0);

    // Randomized traffic with gaps wide enough to never overrun
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 9) < 4) begin
        wr(1, int'($urandom_range(0, 255)));
      end else begin
        k = int'($urandom_range(0, 10));
        case (k)
          0, 1: wr(0, 'hD2);
          2: wr(0, int'($urandom_range(0, 15)));
          3: wr(0, 'h10 + int'($urandom_range(0, 10)));
          4: wr(0, 'h60 + int'($urandom_range(0, 15)));
          5: wr(0, 'h70 + int'($urandom_range(0, 4)));
          6: wr(0, 'h88 + int'($urandom_range(0, 7)));
          7: wr(0, 'hC0 + int'($urandom_range(0, 7)));
          8: wr(0, ($urandom_range(0, 1) == 0) ? 'h81 : 'hA8 + int'($urandom_range(0, 7)));
          9: wr(0, 'h40 + int'($urandom_range(0, 31)));
          default: wr(0, int'($urandom_range(0, 255)));
        endcase
      end
      idle(2);
    end
    check("rand_q_empty", expq.size(), 0);

    // Reset in the middle of a burst
    wr(0, 'hD2); wr(0, 'hAF);
    wr(1, 'h12); wr(1, 'h34);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_px_we", px_we, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_disp_en", disp_en, 0);
    check("mid_rst_scroll", scroll, 0);
    check("mid_rst_pot", pot, 0);
    check("mid_rst_cmd_err", cmd_err, 0);
    model_reset();
    expq.delete();
    @(negedge clk) reset = 1'b1;
    c0 = px_count;
    wr(1, 'h77); idle(3);
    check("post_rst_no_px", px_count - c0, 0);
    check("post_rst_overrun", overrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
